// File: rtl/ifetch_queue.sv
// Fetch stage: drives the icache lookup from the fetch PC, decodes length and
// immediate on a hit, and queues decoded entries for the decode stage.
module ifetch_queue #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_1000,
    parameter int          DEPTH     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] newpc_i,
    output logic [31:0] ic_adr_o,
    output logic        ic_stb_o,
    input  logic        ic_hit_i,
    input  logic [15:0] ic_inst_i,
    input  logic [31:0] ic_data_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] pc_o,
    output logic [15:0] inst_o,
    output logic [31:0] imm_o,
    output logic [1:0]  len_o
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [31:0]   r_pc;
    logic [AW:0]   r_count;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;

    logic [31:0] r_pc_mem   [DEPTH];
    logic [15:0] r_inst_mem [DEPTH];
    logic [31:0] r_imm_mem  [DEPTH];
    logic [1:0]  r_len_mem  [DEPTH];

    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_len;
    logic [31:0] w_imm;

    // Strobe deliberately ignores ready_i: a full queue never accepts a push.
    assign w_full   = (r_count == CNT_FULL);
    assign ic_stb_o = !rst_i && !flush_i && !w_full;
    assign ic_adr_o = r_pc;
    assign w_push   = ic_stb_o && ic_hit_i;
    assign valid_o  = (r_count != '0);
    assign w_pop    = valid_o && ready_i;

    always_comb begin
        w_len = 2'd1;
        if (!ic_inst_i[15]) begin
            case (ic_inst_i[15:8])
                8'h01, 8'h03, 8'h08, 8'h09, 8'h1a, 8'h1b,
                8'h1d, 8'h1f, 8'h20, 8'h22, 8'h24:
                    w_len = 2'd3;
                8'h0c, 8'h0d, 8'h36, 8'h37, 8'h38, 8'h39:
                    w_len = 2'd2;
                default:
                    w_len = 2'd1;
            endcase
        end
    end

    always_comb begin
        w_imm = 32'h0000_0000;
        case (w_len)
            2'd3:    w_imm = ic_data_i;
            2'd2:    w_imm = {16'h0000, ic_data_i[31:16]};
            default: w_imm = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc    <= BOOT_ADDR;
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else if (flush_i) begin
            r_pc    <= {newpc_i[31:1], 1'b0};
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push) begin
                r_pc   <= r_pc + {29'd0, w_len, 1'b0};
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // Entry storage needs no reset; valid_o gates everything read from it.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc_mem[r_wptr]   <= r_pc;
            r_inst_mem[r_wptr] <= ic_inst_i;
            r_imm_mem[r_wptr]  <= w_imm;
            r_len_mem[r_wptr]  <= w_len;
        end
    end

    assign pc_o   = r_pc_mem[r_rptr];
    assign inst_o = r_inst_mem[r_rptr];
    assign imm_o  = r_imm_mem[r_rptr];
    assign len_o  = r_len_mem[r_rptr];

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: the bench plays the icache and decode,
// driving inputs just after each falling edge and checking 1 ns later.
module tb_ifetch_queue;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] newpc_i = '0;
    logic [31:0] ic_adr_o;
    logic        ic_stb_o;
    logic        ic_hit_i = 1'b0;
    logic [15:0] ic_inst_i = '0;
    logic [31:0] ic_data_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] pc_o;
    logic [15:0] inst_o;
    logic [31:0] imm_o;
    logic [1:0]  len_o;

    int errors = 0;
    int checks = 0;

    ifetch_queue dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .newpc_i(newpc_i),
        .ic_adr_o(ic_adr_o), .ic_stb_o(ic_stb_o), .ic_hit_i(ic_hit_i),
        .ic_inst_i(ic_inst_i), .ic_data_i(ic_data_i), .valid_o(valid_o),
        .ready_i(ready_i), .pc_o(pc_o), .inst_o(inst_o), .imm_o(imm_o),
        .len_o(len_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs may then be changed, outputs checked after #1.
    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b1; flush_i = 1'b0; ic_hit_i = 1'b0; ready_i = 1'b0;
        ic_inst_i = '0; ic_data_i = '0; newpc_i = '0;
        step();
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; ready_i = 1'b0; ic_hit_i = 1'b1;
        step(); #1;
        checks++;
        if (ic_stb_o !== 1'b0) begin
            errors++; $display("FAIL reset_stb: got %b want 0", ic_stb_o);
        end
        step();
        rst_i = 1'b0; ic_hit_i = 1'b0;
        #1;
        checks++;
        if (ic_adr_o !== 32'h0000_1000) begin
            errors++; $display("FAIL reset_adr: got %h want 00001000", ic_adr_o);
        end
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", valid_o);
        end
        checks++;
        if (ic_stb_o !== 1'b1) begin
            errors++; $display("FAIL reset_stb_after: got %b want 1", ic_stb_o);
        end
    endtask

    task automatic test_seq16();
        do_reset();
        ready_i = 1'b1; ic_hit_i = 1'b1; ic_inst_i = 16'h9000; ic_data_i = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ic_adr_o !== 32'h1000 + 32'(2*i)) begin
                errors++; $display("FAIL seq16_adr[%0d]: got %h want %h", i, ic_adr_o, 32'h1000 + 32'(2*i));
            end
            step(); #1;
            checks++;
            if (valid_o !== 1'b1 || pc_o !== 32'h1000 + 32'(2*i) || len_o !== 2'd1 || imm_o !== 32'h0) begin
                errors++;
                $display("FAIL seq16_head[%0d]: got v=%b pc=%h len=%0d imm=%h want v=1 pc=%h len=1 imm=0",
                         i, valid_o, pc_o, len_o, imm_o, 32'h1000 + 32'(2*i));
            end
        end
        ic_hit_i = 1'b0;
        step(); #1;
        checks++;
        if (valid_o !== 1'b0 || ic_adr_o !== 32'h1006) begin
            errors++; $display("FAIL seq16_drain: got v=%b adr=%h want v=0 adr=00001006", valid_o, ic_adr_o);
        end
    endtask

    task automatic test_length_decode();
        do_reset();
        ready_i = 1'b0; ic_hit_i = 1'b1; ic_inst_i = 16'h0120; ic_data_i = 32'hDEAD_BEEF;
        step();
        ic_hit_i = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h1000 || inst_o !== 16'h0120 || len_o !== 2'd3 || imm_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL len48_head: got v=%b pc=%h inst=%h len=%0d imm=%h want v=1 pc=00001000 inst=0120 len=3 imm=deadbeef",
                     valid_o, pc_o, inst_o, len_o, imm_o);
        end
        checks++;
        if (ic_adr_o !== 32'h1006) begin
            errors++; $display("FAIL len48_adr: got %h want 00001006", ic_adr_o);
        end
        ready_i = 1'b1; ic_hit_i = 1'b1; ic_inst_i = 16'h0c12; ic_data_i = 32'h1234_ABCD;
        step();
        ic_hit_i = 1'b0; ready_i = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h1006 || len_o !== 2'd2 || imm_o !== 32'h0000_1234) begin
            errors++;
            $display("FAIL len32_head: got v=%b pc=%h len=%0d imm=%h want v=1 pc=00001006 len=2 imm=00001234",
                     valid_o, pc_o, len_o, imm_o);
        end
        checks++;
        if (ic_adr_o !== 32'h100A) begin
            errors++; $display("FAIL len32_adr: got %h want 0000100a", ic_adr_o);
        end
        // bit15 set: same opcode byte pattern as a 48-bit op but form2, so 16-bit
        ready_i = 1'b1; ic_hit_i = 1'b1; ic_inst_i = 16'h8120; ic_data_i = 32'hFFFF_FFFF;
        step();
        ic_hit_i = 1'b1; ready_i = 1'b1; ic_inst_i = 16'h3900; ic_data_i = 32'hBEEF_0000;
        #1;
        checks++;
        if (pc_o !== 32'h100A || len_o !== 2'd1 || imm_o !== 32'h0 || ic_adr_o !== 32'h100C) begin
            errors++;
            $display("FAIL form2_len: got pc=%h len=%0d imm=%h adr=%h want pc=0000100a len=1 imm=0 adr=0000100c",
                     pc_o, len_o, imm_o, ic_adr_o);
        end
        step();
        ic_hit_i = 1'b0; ready_i = 1'b0;
        #1;
        checks++;
        if (pc_o !== 32'h100C || len_o !== 2'd2 || imm_o !== 32'h0000_BEEF || ic_adr_o !== 32'h1010) begin
            errors++;
            $display("FAIL op39_len: got pc=%h len=%0d imm=%h adr=%h want pc=0000100c len=2 imm=0000beef adr=00001010",
                     pc_o, len_o, imm_o, ic_adr_o);
        end
    endtask

    task automatic test_miss();
        do_reset();
        ready_i = 1'b0; ic_hit_i = 1'b0; ic_inst_i = 16'h9000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ic_stb_o !== 1'b1 || ic_adr_o !== 32'h1000 || valid_o !== 1'b0) begin
                errors++;
                $display("FAIL miss_hold[%0d]: got stb=%b adr=%h v=%b want stb=1 adr=00001000 v=0",
                         i, ic_stb_o, ic_adr_o, valid_o);
            end
            step(); #1;
        end
        ic_hit_i = 1'b1;
        step();
        ic_hit_i = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h1000 || ic_adr_o !== 32'h1002) begin
            errors++;
            $display("FAIL miss_hit: got v=%b pc=%h adr=%h want v=1 pc=00001000 adr=00001002", valid_o, pc_o, ic_adr_o);
        end
        ready_i = 1'b1;
        step(); #1;
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL miss_single_push: got v=%b want 0 after one pop", valid_o);
        end
    endtask

    task automatic test_full();
        do_reset();
        ready_i = 1'b0; ic_hit_i = 1'b1; ic_inst_i = 16'h9000;
        for (int i = 0; i < 4; i++) step();
        #1;
        checks++;
        if (ic_stb_o !== 1'b0 || ic_adr_o !== 32'h1008) begin
            errors++; $display("FAIL full_stall: got stb=%b adr=%h want stb=0 adr=00001008", ic_stb_o, ic_adr_o);
        end
        ready_i = 1'b1;
        #1;
        checks++;
        if (ic_stb_o !== 1'b0) begin
            errors++; $display("FAIL full_no_ready_path: got stb=%b want 0", ic_stb_o);
        end
        step();
        ic_hit_i = 1'b0;
        #1;
        checks++;
        if (pc_o !== 32'h1002 || ic_adr_o !== 32'h1008 || ic_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_no_push: got head=%h adr=%h stb=%b want head=00001002 adr=00001008 stb=1",
                     pc_o, ic_adr_o, ic_stb_o);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (valid_o !== 1'b1 || pc_o !== 32'h1002 + 32'(2*i)) begin
                errors++; $display("FAIL full_drain[%0d]: got v=%b pc=%h want v=1 pc=%h", i, valid_o, pc_o, 32'h1002 + 32'(2*i));
            end
            step(); #1;
        end
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL full_empty: got v=%b want 0", valid_o);
        end
        ready_i = 1'b0; ic_hit_i = 1'b1;
        step();
        ic_hit_i = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h1008 || ic_adr_o !== 32'h100A) begin
            errors++;
            $display("FAIL full_resume: got v=%b pc=%h adr=%h want v=1 pc=00001008 adr=0000100a", valid_o, pc_o, ic_adr_o);
        end
    endtask

    task automatic test_flush();
        do_reset();
        ready_i = 1'b0; ic_hit_i = 1'b1; ic_inst_i = 16'h9000;
        for (int i = 0; i < 3; i++) step();
        flush_i = 1'b1; newpc_i = 32'h2001; ready_i = 1'b1;
        #1;
        checks++;
        if (ic_stb_o !== 1'b0) begin
            errors++; $display("FAIL flush_stb: got %b want 0", ic_stb_o);
        end
        step();
        flush_i = 1'b0; ic_hit_i = 1'b0; ready_i = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || ic_adr_o !== 32'h2000 || ic_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_redirect: got v=%b adr=%h stb=%b want v=0 adr=00002000 stb=1", valid_o, ic_adr_o, ic_stb_o);
        end
        ic_hit_i = 1'b1; ic_inst_i = 16'h0120; ic_data_i = 32'h1111_2222;
        step();
        ic_hit_i = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h2000 || len_o !== 2'd3 || imm_o !== 32'h1111_2222) begin
            errors++;
            $display("FAIL flush_first: got v=%b pc=%h len=%0d imm=%h want v=1 pc=00002000 len=3 imm=11112222",
                     valid_o, pc_o, len_o, imm_o);
        end
        ready_i = 1'b1;
        step(); #1;
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL flush_discarded: got v=%b pc=%h want v=0", valid_o, pc_o);
        end
        // Redirect to the top of the address space to exercise PC wrap-around.
        ready_i = 1'b0; flush_i = 1'b1; newpc_i = 32'hFFFF_FFFF;
        step();
        flush_i = 1'b0; ic_hit_i = 1'b1; ic_inst_i = 16'h9000;
        step();
        ic_hit_i = 1'b0;
        #1;
        checks++;
        if (pc_o !== 32'hFFFF_FFFE || ic_adr_o !== 32'h0) begin
            errors++; $display("FAIL pc_wrap: got head=%h adr=%h want head=fffffffe adr=00000000", pc_o, ic_adr_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ready_i = 1'b0; ic_hit_i = 1'b1; ic_inst_i = 16'h9000;
        step(); step();
        ic_hit_i = 1'b0;
        step(); step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || ic_adr_o !== 32'h1000 || ic_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got v=%b adr=%h stb=%b want v=0 adr=00001000 stb=1", valid_o, ic_adr_o, ic_stb_o);
        end
    endtask

    initial begin
        test_reset();
        test_seq16();
        test_length_decode();
        test_miss();
        test_full();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Fetch stage directly downstream of the mox125 instruction cache.
- Owns the fetch PC and presents it to the cache as a combinational lookup address with a strobe.
- On a cache hit, decodes the instruction length, extracts the immediate, pushes one entry into a small FIFO and advances the PC by 2, 4 or 6 bytes.
- Decode drains the FIFO with a valid/ready handshake; a flush from execute redirects the PC and empties the FIFO.

Parameters:
- BOOT_ADDR, 32'h00001000, PC value loaded on reset.
- DEPTH, 4, FIFO entries (power of two, at least 2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  redirect request from execute.
- newpc_i  in  32  redirect target; bit 0 ignored (forced to 0).
- ic_adr_o  out  32  lookup address to the icache (the fetch PC register).
- ic_stb_o  out  1  lookup strobe to the icache.
- ic_hit_i  in  1  icache hit; combinational on ic_adr_o.
- ic_inst_i  in  16  instruction halfword at ic_adr_o.
- ic_data_i  in  32  the two halfwords following ic_adr_o (ic_adr_o+2 in [31:16], ic_adr_o+4 in [15:0]).
- valid_o  out  1  FIFO head entry valid.
- ready_i  in  1  decode accepts the head entry this cycle.
- pc_o  out  32  PC of the head entry.
- inst_o  out  16  opcode halfword of the head entry.
- imm_o  out  32  immediate of the head entry.
- len_o  out  2  length of the head entry: 1=16b, 2=32b, 3=48b.

Behaviour:
Interface and reset:
- Single clock clk_i; reset rst_i is synchronous and active-high.
- Reset: pc<=BOOT_ADDR, FIFO count=0, read/write pointers=0.
- Reset values: valid_o=0, ic_stb_o=0 on the reset cycle, ic_adr_o=BOOT_ADDR; pc_o/inst_o/imm_o/len_o are don't-care while valid_o=0.
- A reset asserted while the icache is mid-fill is safe: the icache resets on the same rst_i.

Cache lookup:
- ic_stb_o = !rst_i & !flush_i & (count<DEPTH).
- ic_adr_o = pc, held stable while waiting on a miss.
- The icache samples its strobe only when idle, so deasserting ic_stb_o during a fill is legal.
- push = ic_stb_o & ic_hit_i. Latency is zero extra cycles: a hit pushes at the same clock edge it is seen.

Length decode (from ic_inst_i):
- Form1 when bit15=0; opcode = ic_inst_i[15:8].
- 48-bit: opcodes 0x01,0x03,0x08,0x09,0x1a,0x1b,0x1d,0x1f,0x20,0x22,0x24.
- 32-bit: opcodes 0x0c,0x0d,0x36,0x37,0x38,0x39.
- All other form1 opcodes and all form2/form3 (bit15=1) are 16-bit.

Immediate extraction:
- len 3: imm = ic_data_i.
- len 2: imm = {16'h0000, ic_data_i[31:16]}; decode performs any sign extension.
- len 1: imm = 0.

Push (a single push/pop handles each instruction atomically):
- Write {pc, ic_inst_i, imm, len} at the write pointer.
- pc <= pc + 2*len, 32-bit wrap-around (32'hFFFFFFFE + 2 = 0).
- Pointers are log2(DEPTH) bits and wrap.
- pop = valid_o & ready_i; valid_o = (count!=0). Head outputs are read combinationally from the read pointer.

FIFO boundaries:
- Push and pop in the same cycle leave count unchanged.
- Full (count==DEPTH): no push, even if a pop occurs the same cycle; there is no combinational path ready_i->ic_stb_o.
- Empty: no pop, and ready_i is ignored.

Flush:
- flush_i has priority over push and pop.
- Effects: pc <= {newpc_i[31:1],1'b0}, count/pointers <= 0, valid_o=0 from the next cycle.
- The cache hit in the flush cycle is discarded.
- Lookup of the new PC begins the cycle after the flush.

No FSM beyond the FIFO count. A miss simply holds the PC with the strobe asserted until a hit.

Test Plan:
1. Reset, then a cache model hitting with 16-bit ops (0x9000) and ready_i=1 -> fetch starts at 0x1000; entries at pc 0x1000,0x1002,0x1004; len=1; imm=0; one entry per cycle.
2. ic_inst_i=0x0120 (ldi.l) at 0x1000, ic_data_i=0xDEADBEEF -> entry len=3, imm=0xDEADBEEF; next ic_adr_o=0x1006. Then 0x0c12 (ldo.l) with data 0x1234xxxx -> len=2, imm=0x00001234; next adr 0x100A.
3. Miss for 5 cycles then hit -> ic_adr_o and ic_stb_o held steady, no push during the miss, exactly one push on the hit.
4. ready_i=0 with continuous hits -> exactly 4 pushes; ic_stb_o drops when count=4; no push on a simultaneous pop at full. Release ready_i -> entries drain in order; fetch resumes.
5. Queue holding 3 entries, flush_i=1 with newpc_i=0x2001 and a hit in the same cycle -> next cycle valid_o=0, ic_adr_o=0x2000; discarded entries never appear.
6. Assert rst_i mid-miss and with a non-empty queue -> next cycle valid_o=0, ic_adr_o=0x1000, ic_stb_o=1.
